// File: rtl/sine_nco.sv
// Sine NCO: prescaled phase accumulator driving a sine ROM address, with
// latency-matched capture of the returned ROM samples.
module sine_nco #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 10,
   parameter int unsigned PHASE_W     = 24,
   parameter int unsigned TUNE_W      = 10,
   parameter int unsigned TICK_DIV    = 50,
   parameter int unsigned ROM_LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic              i_sync,
   input  logic [TUNE_W-1:0] i_tuning,
   output logic [ADDR_W-1:0] o_romAddress,
   input  logic [DATA_W-1:0] i_romData,
   output logic [DATA_W-1:0] o_sample,
   output logic              o_sampleValid,
   output logic              o_wrap
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [ROM_LATENCY:0] tok_q, tok_d;
   logic [DATA_W-1:0]  sample_q, sample_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;
   logic               tick;
   logic [PHASE_W:0]   sum;

   always_comb begin
      tick     = i_enable && !i_sync && (cnt_q == CNT_MAX);
      sum      = {1'b0, phase_q} + (PHASE_W + 1)'(i_tuning);
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      tok_d    = tok_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      wrap_d   = 1'b0;
      if (i_sync) begin
         // Clearing the token pipe discards in-flight samples; o_sample keeps its value.
         cnt_d   = '0;
         phase_d = '0;
         tok_d   = '0;
      end else begin
         if (tick) begin
            cnt_d   = '0;
            phase_d = sum[PHASE_W-1:0];
            wrap_d  = sum[PHASE_W];
         end else if (i_enable) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         // Stage 0 marks the address update; the remaining stages cover the ROM latency.
         tok_d   = {tok_q[ROM_LATENCY-1:0], tick};
         valid_d = tok_q[ROM_LATENCY];
         if (tok_q[ROM_LATENCY]) begin
            sample_d = i_romData;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         phase_q  <= '0;
         tok_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         tok_q    <= tok_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
      end
   end

   assign o_romAddress  = phase_q[PHASE_W-1 -: ADDR_W];
   assign o_sample      = sample_q;
   assign o_sampleValid = valid_q;
   assign o_wrap        = wrap_q;

endmodule

// File: tb/tb_sine_nco.sv
// Bench for sine_nco: two instances (TICK_DIV 4 and 1, PHASE_W 12) with ROM models,
// checked every cycle against an arithmetic tick/sample-history model.
module tb_sine_nco;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       sync = 1'b0;
   logic [9:0] tuning = '0;

   logic [9:0] addr_o   [2];
   logic [9:0] sample_o [2];
   logic       valid_o  [2];
   logic       wrap_o   [2];
   logic [9:0] rom_r1   [2];
   logic [9:0] rom_r2   [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int td [2] = '{4, 1};
   int m_cnt [2];
   int m_phase [2];
   int m_last_clear [2];
   int hist_cyc [2][8];
   int hist_val [2][8];
   int exp_sample [2];
   logic exp_valid [2];
   logic exp_wrap [2];

   always #5 clk = ~clk;

   sine_nco #(.ADDR_W(10), .DATA_W(10), .PHASE_W(12), .TUNE_W(10), .TICK_DIV(4),
              .ROM_LATENCY(2)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sync(sync), .i_tuning(tuning),
      .o_romAddress(addr_o[0]), .i_romData(rom_r2[0]), .o_sample(sample_o[0]),
      .o_sampleValid(valid_o[0]), .o_wrap(wrap_o[0])
   );

   sine_nco #(.ADDR_W(10), .DATA_W(10), .PHASE_W(12), .TUNE_W(10), .TICK_DIV(1),
              .ROM_LATENCY(2)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sync(sync), .i_tuning(tuning),
      .o_romAddress(addr_o[1]), .i_romData(rom_r2[1]), .o_sample(sample_o[1]),
      .o_sampleValid(valid_o[1]), .o_wrap(wrap_o[1])
   );

   // ROM model: two-clock latency, q = address + 3.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         rom_r1[i] <= addr_o[i];
         rom_r2[i] <= rom_r1[i] + 10'd3;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // A sample is due 3 edges after its tick unless a sync/reset edge came after the tick.
   task automatic model_edge();
      int sum;
      for (int i = 0; i < 2; i++) begin
         exp_wrap[i]  = 1'b0;
         exp_valid[i] = 1'b0;
         if (!rst_n) begin
            m_cnt[i] = 0;
            m_phase[i] = 0;
            m_last_clear[i] = cyc;
            exp_sample[i] = 0;
         end else if (sync) begin
            m_cnt[i] = 0;
            m_phase[i] = 0;
            m_last_clear[i] = cyc;
         end else if (enable && m_cnt[i] == td[i] - 1) begin
            sum = m_phase[i] + int'(tuning);
            exp_wrap[i] = (sum >= 4096);
            m_phase[i] = sum % 4096;
            m_cnt[i] = 0;
            hist_cyc[i][cyc % 8] = cyc;
            hist_val[i][cyc % 8] = ((m_phase[i] / 4) + 3) % 1024;
         end else if (enable) begin
            m_cnt[i]++;
         end
         if (cyc >= 3 && hist_cyc[i][(cyc - 3) % 8] == cyc - 3 && m_last_clear[i] <= cyc - 3)
         begin
            exp_valid[i] = 1'b1;
            exp_sample[i] = hist_val[i][(cyc - 3) % 8];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("addr%0d@%0d", i, cyc), 32'(addr_o[i]), 32'(m_phase[i] / 4));
         chk($sformatf("sample%0d@%0d", i, cyc), 32'(sample_o[i]), 32'(exp_sample[i]));
         chk($sformatf("valid%0d@%0d", i, cyc), 32'(valid_o[i]), 32'(exp_valid[i]));
         chk($sformatf("wrap%0d@%0d", i, cyc), 32'(wrap_o[i]), 32'(exp_wrap[i]));
      end
   endtask

   // Assert reset between edges and confirm outputs clear without a clock edge.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("arst_addr%0d", i), 32'(addr_o[i]), 0);
         chk($sformatf("arst_sample%0d", i), 32'(sample_o[i]), 0);
         chk($sformatf("arst_valid%0d", i), 32'(valid_o[i]), 0);
         chk($sformatf("arst_wrap%0d", i), 32'(wrap_o[i]), 0);
         m_cnt[i] = 0;
         m_phase[i] = 0;
         m_last_clear[i] = cyc + 1;
         exp_sample[i] = 0;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_phase[i] = 0;
         m_last_clear[i] = 0;
         exp_sample[i] = 0;
         for (int j = 0; j < 8; j++) begin
            hist_cyc[i][j] = -100;
            hist_val[i][j] = 0;
         end
      end

      // Reset held
      repeat (3) step();
      chk("rst_addr", 32'(addr_o[0]), 0);
      chk("rst_valid", 32'(valid_o[0]), 0);

      // Stepping: tuning 4, one address step per tick
      rst_n = 1'b1;
      enable = 1'b1;
      tuning = 10'd4;
      repeat (4) step();
      chk("step_addr_first_tick", 32'(addr_o[0]), 1);
      repeat (3) step();
      chk("step_valid", 32'(valid_o[0]), 1);
      chk("step_sample", 32'(sample_o[0]), 4);
      chk("b2b_valid", 32'(valid_o[1]), 1);
      chk("b2b_sample", 32'(sample_o[1]), 7);
      repeat (12) step();

      // Async reset mid-pipeline
      async_reset();
      step();
      rst_n = 1'b1;
      repeat (6) step();

      // Wrap: 5 ticks of 1000 in a 12-bit phase
      sync = 1'b1;
      tuning = 10'd1000;
      step();
      sync = 1'b0;
      repeat (20) step();
      chk("wrap_addr", 32'(addr_o[0]), 226);
      chk("wrap_pulse", 32'(wrap_o[0]), 1);
      step();
      chk("wrap_single", 32'(wrap_o[0]), 0);

      // Sync one clock after a tick discards the in-flight sample
      repeat (3) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_addr", 32'(addr_o[0]), 0);
      repeat (3) step();
      chk("sync_no_valid", 32'(valid_o[0]), 0);
      chk("sync_sample_held", 32'(sample_o[0]), 229);
      step();
      chk("sync_next_tick", 32'(addr_o[0]), 250);

      // Enable dropped in the tick cycle
      repeat (3) step();
      enable = 1'b0;
      repeat (20) step();
      chk("pause_addr", 32'(addr_o[0]), 250);
      enable = 1'b1;
      step();
      chk("resume_addr", 32'(addr_o[0]), 500);
      repeat (4) step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         enable = ($urandom % 8) != 0;
         sync = ($urandom % 32) == 0;
         tuning = 10'($urandom);
         if ($urandom % 64 == 0) begin
            async_reset();
            step();
            rst_n = 1'b1;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sine_nco.md
Name: sine_nco

Overview:
- Numerically-controlled oscillator that drives the address port of the sine-wave table ROM and captures the returned samples.
- A phase accumulator steps by a tuning word once per prescaled sample tick.
- The top ADDR_W bits of the phase form the ROM address.
- The ROM output is captured after a fixed read latency and presented as a valid-flagged sample for downstream consumers (7-segment display, PWM/DAC driver).

Parameters:
- ADDR_W, 10, ROM address width; also the number of phase bits used as the address.
- DATA_W, 10, ROM data and sample width.
- PHASE_W, 24, phase accumulator width; must be >= ADDR_W.
- TUNE_W, 10, tuning-word width; zero-extended to PHASE_W; must be <= PHASE_W.
- TICK_DIV, 50, clocks per sample tick; must be >= 1.
- ROM_LATENCY, 2, clocks from an address change to valid ROM data; must be >= 1.

Ports:
- i_clk  input  1  system clock (CLOCK_50)
- i_rst_n  input  1  reset, asynchronous, active-low
- i_enable  input  1  1 = run; 0 = freeze prescaler and phase
- i_sync  input  1  synchronous phase clear; single-cycle or level
- i_tuning  input  TUNE_W  phase increment per tick; unsigned
- o_romAddress  output  ADDR_W  ROM address = phase[PHASE_W-1 -: ADDR_W]
- i_romData  input  DATA_W  ROM q output
- o_sample  output  DATA_W  last captured ROM sample
- o_sampleValid  output  1  one-cycle pulse when o_sample updates
- o_wrap  output  1  one-cycle pulse when the phase accumulator overflows

Behaviour:
- Async reset (i_rst_n=0) clears all state immediately:
  - prescaler=0, phase=0 (o_romAddress=0)
  - valid pipeline=0
  - o_sample=0, o_sampleValid=0, o_wrap=0
- Release is synchronous to i_clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 while i_enable=1; holds while i_enable=0.
  - tick = i_enable && (prescaler == TICK_DIV-1); the counter returns to 0 on tick.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- Phase update on tick:
  - phase <= (phase + zero_ext(i_tuning)) mod 2^PHASE_W.
  - i_tuning is sampled only in the tick cycle.
  - i_tuning=0 keeps the phase constant, but samples are still produced every tick.
- Wrap:
  - o_wrap=1 in the cycle after a tick whose addition carried out of bit PHASE_W-1; otherwise 0.
  - A sum landing exactly on 2^PHASE_W counts as a wrap (phase becomes 0).
- o_romAddress is driven directly from the phase register and changes in the cycle after the tick.
- Sample capture:
  - A ROM_LATENCY-deep shift register carries a token launched by each tick.
  - When the token exits (ROM_LATENCY+1 clocks after the tick edge), o_sample <= i_romData and o_sampleValid=1 for exactly one cycle.
  - Tokens from back-to-back ticks (TICK_DIV=1) pipeline independently, giving one valid per tick.
- i_sync, synchronous, highest priority:
  - Clears prescaler, phase and the token pipeline; no tick fires in that cycle.
  - In-flight samples are discarded (no o_sampleValid for them).
  - o_sample holds its last value.
  - o_wrap is 0 in the following cycle.
  - While i_sync is held high, everything stays cleared.
- i_enable=0:
  - No new ticks; phase and prescaler hold.
  - Tokens already in flight still drain and produce o_sampleValid.
  - Re-enabling resumes the prescaler from its held count.
- Simultaneous i_sync and tick: i_sync wins; phase ends at 0 with no token launched.
- Reset asserted mid-pipeline: all tokens are lost; no valid is produced after release until a new tick.

Test Plan:
- Reset with PHASE_W=12, TICK_DIV=4, ROM_LATENCY=2:
  - Hold i_rst_n=0 → o_romAddress=0, o_sample=0, o_sampleValid=0, o_wrap=0.
  - Assert reset asynchronously between edges → outputs clear without a clock edge.
- Stepping, same config, i_tuning=4, i_enable=1, ROM model q=address+3:
  - o_romAddress steps 0→1→2… every 4 clocks.
  - o_sampleValid pulses every 4 clocks, 3 clocks after each tick.
  - o_sample = new address + 3.
- Wrap, i_tuning=1000, PHASE_W=12:
  - After 5 ticks the phase goes 4000→904 (5000 mod 4096).
  - o_wrap pulses once, in the cycle after the 5th tick.
  - o_romAddress=226.
- Back-to-back, TICK_DIV=1, i_tuning=4:
  - One o_sampleValid per clock after a 3-cycle fill.
  - Samples track consecutive addresses with none dropped.
- Sync, asserted one clock after a tick:
  - The in-flight sample produces no o_sampleValid; phase=0; o_sample unchanged.
  - The next tick occurs TICK_DIV clocks after i_sync deasserts.
- Enable pause, i_enable dropped in the tick cycle:
  - No tick fires; the phase holds for 20 clocks; the prior token's valid still appears.
  - On re-enable, the prescaler resumes from 3 and the next tick fires on the first enabled clock.
